// File: rtl/flag_branch_pkg.sv
// Shared types for the flag/branch unit: FSM states, branch condition codes, widths.
package flag_branch_pkg;

  localparam int unsigned DATA_W = 4;
  localparam int unsigned COND_W = 3;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_FLUSH = 2'd1,
    ST_HALT  = 2'd2
  } state_e;

  typedef enum logic [COND_W-1:0] {
    COND_ALWAYS = 3'b000,
    COND_Z      = 3'b001,
    COND_NZ     = 3'b010,
    COND_C      = 3'b011,
    COND_NC     = 3'b100,
    COND_NEVER0 = 3'b101,
    COND_NEVER1 = 3'b110,
    COND_HALT   = 3'b111
  } cond_e;

  // Sequential program counter step; wraps naturally at 2**DATA_W.
  function automatic logic [DATA_W-1:0] pc_step(input logic [DATA_W-1:0] pc);
    return pc + DATA_W'(1);
  endfunction

endpackage

// File: rtl/flag_branch_cond_eval.sv
// Branch condition decoder: evaluates a condition code against the latched flags.
module cond_eval
  import flag_branch_pkg::*;
(
  input  logic              z,
  input  logic              cf,
  input  logic [COND_W-1:0] br_cond,
  output logic              take,
  output logic              halt
);

  always_comb begin
    take = 1'b0;
    halt = 1'b0;
    case (br_cond)
      COND_ALWAYS: take = 1'b1;
      COND_Z:      take = z;
      COND_NZ:     take = ~z;
      COND_C:      take = cf;
      COND_NC:     take = ~cf;
      COND_NEVER0: take = 1'b0;
      COND_NEVER1: take = 1'b0;
      COND_HALT:   halt = 1'b1;
      default:     take = 1'b0;
    endcase
  end

endmodule

// File: rtl/flag_branch_unit.sv
// Latches ALU result/flags and sequences the PC with conditional branches,
// a one-cycle post-branch flush and a terminal halt state.
module flag_branch_unit
  import flag_branch_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              pc_en,
  input  logic              res_valid,
  input  logic [DATA_W-1:0] res,
  input  logic              z_in,
  input  logic              cf_in,
  input  logic              br_valid,
  input  logic [COND_W-1:0] br_cond,
  input  logic [DATA_W-1:0] br_target,
  output logic [DATA_W-1:0] acc,
  output logic              z,
  output logic              cf,
  output logic [DATA_W-1:0] pc,
  output logic              br_taken,
  output logic              halted
);

  state_e            state_q;
  state_e            state_d;
  logic [DATA_W-1:0] acc_d;
  logic [DATA_W-1:0] pc_d;
  logic              z_d;
  logic              cf_d;
  logic              br_taken_d;
  logic              halted_d;
  logic              cond_take;
  logic              cond_halt;

  // Decisions use the registered flags, so a same-cycle ALU update cannot steer a branch.
  cond_eval u_cond_eval (
    .z       (z),
    .cf      (cf),
    .br_cond (br_cond),
    .take    (cond_take),
    .halt    (cond_halt)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_RUN;
      acc      <= '0;
      z        <= 1'b0;
      cf       <= 1'b0;
      pc       <= '0;
      br_taken <= 1'b0;
      halted   <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc      <= acc_d;
      z        <= z_d;
      cf       <= cf_d;
      pc       <= pc_d;
      br_taken <= br_taken_d;
      halted   <= halted_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    acc_d      = acc;
    z_d        = z;
    cf_d       = cf;
    pc_d       = pc;
    br_taken_d = 1'b0;

    // Result latch is live in RUN and FLUSH, frozen only in HALT.
    if (res_valid && (state_q != ST_HALT)) begin
      acc_d = res;
      z_d   = z_in;
      cf_d  = cf_in;
    end

    case (state_q)
      ST_RUN: begin
        if (pc_en) begin
          if (br_valid && cond_halt) begin
            state_d = ST_HALT;
          end else if (br_valid && cond_take) begin
            pc_d       = br_target;
            br_taken_d = 1'b1;
            state_d    = ST_FLUSH;
          end else begin
            pc_d = pc_step(pc);
          end
        end
      end
      ST_FLUSH: state_d = ST_RUN;
      ST_HALT:  state_d = ST_HALT;
      default:  state_d = ST_RUN;
    endcase

    halted_d = (state_d == ST_HALT);
  end

endmodule

// File: tb/tb_flag_branch_unit.sv
// Directed bench for flag_branch_unit: the driver queues hand-computed expectations,
// a monitor compares them against the outputs after each clock edge.
module tb_flag_branch_unit;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       pc_en = 1'b0;
  logic       res_valid = 1'b0;
  logic [3:0] res = '0;
  logic       z_in = 1'b0;
  logic       cf_in = 1'b0;
  logic       br_valid = 1'b0;
  logic [2:0] br_cond = '0;
  logic [3:0] br_target = '0;
  logic [3:0] acc;
  logic       z;
  logic       cf;
  logic [3:0] pc;
  logic       br_taken;
  logic       halted;

  typedef struct {
    logic [11:0] v;
    string       nm;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  flag_branch_unit dut (
    .clk       (clk),
    .rst       (rst),
    .pc_en     (pc_en),
    .res_valid (res_valid),
    .res       (res),
    .z_in      (z_in),
    .cf_in     (cf_in),
    .br_valid  (br_valid),
    .br_cond   (br_cond),
    .br_target (br_target),
    .acc       (acc),
    .z         (z),
    .cf        (cf),
    .pc        (pc),
    .br_taken  (br_taken),
    .halted    (halted)
  );

  always #5 clk = ~clk;

  // Drive one cycle of inputs and queue the outputs expected after the next rising edge.
  task automatic step(input logic r, input logic en, input logic rv, input logic [3:0] rs,
                      input logic zi, input logic ci, input logic bv, input logic [2:0] bc,
                      input logic [3:0] tgt, input logic [3:0] e_acc, input logic e_z,
                      input logic e_cf, input logic [3:0] e_pc, input logic e_bt,
                      input logic e_h, input string nm);
    exp_t e;
    @(negedge clk);
    rst = r; pc_en = en; res_valid = rv; res = rs; z_in = zi; cf_in = ci;
    br_valid = bv; br_cond = bc; br_target = tgt;
    e.v  = {e_acc, e_z, e_cf, e_pc, e_bt, e_h};
    e.nm = nm;
    sb.push_back(e);
  endtask

  // Monitor: every edge presents a new output set; compare against the queued entry.
  always @(posedge clk) begin
    exp_t e;
    logic [11:0] got;
    #1;
    if (sb.size() > 0) begin
      e   = sb.pop_front();
      got = {acc, z, cf, pc, br_taken, halted};
      checks++;
      if (got !== e.v) begin
        errors++;
        $display("FAIL %s: got acc=%h z=%b cf=%b pc=%h bt=%b halted=%b, expected acc=%h z=%b cf=%b pc=%h bt=%b halted=%b",
                 e.nm, got[11:8], got[7], got[6], got[5:2], got[1], got[0],
                 e.v[11:8], e.v[7], e.v[6], e.v[5:2], e.v[1], e.v[0]);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // r en rv res zi ci bv cond tgt | acc z cf pc bt h
    step(1, 1, 1, 4'hF, 1, 1, 1, 3'd0, 4'h7, 4'h0, 0, 0, 4'h0, 0, 0, "reset");
    for (int i = 1; i <= 17; i++)
      step(0, 1, 0, 4'h0, 0, 0, 0, 3'd0, 4'h0, 4'h0, 0, 0, 4'(i % 16), 0, 0, "pc_count");

    step(0, 1, 1, 4'h0, 1, 0, 0, 3'd0, 4'h0, 4'h0, 1, 0, 4'h2, 0, 0, "res_load_z");
    step(0, 1, 0, 4'h0, 0, 0, 1, 3'd1, 4'h9, 4'h0, 1, 0, 4'h9, 1, 0, "br_z_taken");
    step(0, 1, 0, 4'h0, 0, 0, 1, 3'd0, 4'h3, 4'h0, 1, 0, 4'h9, 0, 0, "flush_hold");
    step(0, 1, 0, 4'h0, 0, 0, 0, 3'd0, 4'h0, 4'h0, 1, 0, 4'hA, 0, 0, "after_flush");

    step(0, 1, 1, 4'hA, 0, 1, 0, 3'd0, 4'h0, 4'hA, 0, 1, 4'hB, 0, 0, "res_load_c");
    step(0, 1, 0, 4'h0, 0, 0, 1, 3'd3, 4'h4, 4'hA, 0, 1, 4'h4, 1, 0, "br_c_taken");
    step(0, 1, 1, 4'h5, 0, 0, 0, 3'd0, 4'h0, 4'h5, 0, 0, 4'h4, 0, 0, "flush_res_load");
    step(0, 1, 0, 4'h0, 0, 0, 1, 3'd4, 4'hE, 4'h5, 0, 0, 4'hE, 1, 0, "br_nc_taken");
    step(0, 1, 0, 4'h0, 0, 0, 0, 3'd0, 4'h0, 4'h5, 0, 0, 4'hE, 0, 0, "flush_nc");
    step(0, 1, 0, 4'h0, 0, 0, 1, 3'd5, 4'h1, 4'h5, 0, 0, 4'hF, 0, 0, "br_never5");
    step(0, 1, 0, 4'h0, 0, 0, 1, 3'd6, 4'h1, 4'h5, 0, 0, 4'h0, 0, 0, "br_never6_wrap");
    step(0, 1, 0, 4'h0, 0, 0, 1, 3'd2, 4'h7, 4'h5, 0, 0, 4'h7, 1, 0, "br_nz_taken");
    step(0, 1, 0, 4'h0, 0, 0, 0, 3'd0, 4'h0, 4'h5, 0, 0, 4'h7, 0, 0, "flush_nz");
    step(0, 1, 0, 4'h0, 0, 0, 1, 3'd1, 4'h2, 4'h5, 0, 0, 4'h8, 0, 0, "br_z_not_taken");
    step(0, 0, 1, 4'h6, 0, 0, 1, 3'd0, 4'h2, 4'h6, 0, 0, 4'h8, 0, 0, "pc_en_low");
    step(0, 1, 0, 4'h0, 0, 0, 1, 3'd0, 4'h8, 4'h6, 0, 0, 4'h8, 1, 0, "br_self_target");
    step(0, 1, 0, 4'h0, 0, 0, 0, 3'd0, 4'h0, 4'h6, 0, 0, 4'h8, 0, 0, "flush_self");
    step(0, 1, 0, 4'h0, 0, 0, 0, 3'd0, 4'h0, 4'h6, 0, 0, 4'h9, 0, 0, "after_self");

    step(0, 1, 1, 4'h3, 1, 0, 1, 3'd1, 4'h2, 4'h3, 1, 0, 4'hA, 0, 0, "same_cycle_z");
    step(0, 1, 0, 4'h0, 0, 0, 1, 3'd1, 4'h2, 4'h3, 1, 0, 4'h2, 1, 0, "br_z_registered");
    step(0, 1, 0, 4'h0, 0, 0, 0, 3'd0, 4'h0, 4'h3, 1, 0, 4'h2, 0, 0, "flush_z");
    step(0, 1, 0, 4'h0, 0, 0, 0, 3'd0, 4'h0, 4'h3, 1, 0, 4'h3, 0, 0, "run_3");
    step(0, 1, 0, 4'h0, 0, 0, 0, 3'd0, 4'h0, 4'h3, 1, 0, 4'h4, 0, 0, "run_4");
    step(0, 1, 0, 4'h0, 0, 0, 0, 3'd0, 4'h0, 4'h3, 1, 0, 4'h5, 0, 0, "run_5");

    step(0, 1, 0, 4'h0, 0, 0, 1, 3'd7, 4'h0, 4'h3, 1, 0, 4'h5, 0, 1, "halt_enter");
    for (int i = 0; i < 10; i++)
      step(0, 1, 1, 4'hF, 0, 1, 1, 3'd0, 4'h1, 4'h3, 1, 0, 4'h5, 0, 1, "halt_frozen");
    step(1, 1, 1, 4'hF, 1, 1, 1, 3'd0, 4'h1, 4'h0, 0, 0, 4'h0, 0, 0, "rst_from_halt");

    step(0, 1, 0, 4'h0, 0, 0, 0, 3'd0, 4'h0, 4'h0, 0, 0, 4'h1, 0, 0, "run_after_halt");
    step(0, 1, 0, 4'h0, 0, 0, 1, 3'd0, 4'hC, 4'h0, 0, 0, 4'hC, 1, 0, "br_before_rst");
    step(1, 1, 1, 4'h9, 1, 1, 1, 3'd0, 4'h3, 4'h0, 0, 0, 4'h0, 0, 0, "rst_in_flush");
    step(0, 1, 0, 4'h0, 0, 0, 0, 3'd0, 4'h0, 4'h0, 0, 0, 4'h1, 0, 0, "run_after_flush_rst");

    @(negedge clk);
    pc_en = 1'b0; br_valid = 1'b0; res_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending entries, expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/flag_branch_unit.md
FLAG_BRANCH_UNIT -- requirements
Module: flag_branch_unit

Interface
REQ-001 The block SHALL use one clock; reset is synchronous and active-high.
REQ-002 Parameter: none; all datapaths SHALL be 4 bits, matching the ALU op modules.
REQ-003 CLK  in  1  rising-edge clock.
REQ-004 RST  in  1  synchronous active-high reset.
REQ-005 PC_EN  in  1  advance/branch enable; low SHALL freeze PC and ignore BR_VALID.
REQ-006 RES_VALID  in  1  ALU result present this cycle.
REQ-007 RES  in  4  ALU OUT value.
REQ-008 Z_IN  in  1  ALU Z flag.
REQ-009 CF_IN  in  1  ALU CF flag.
REQ-010 BR_VALID  in  1  branch request this cycle.
REQ-011 BR_COND  in  3  condition code.
REQ-012 BR_TARGET  in  4  branch destination.
REQ-013 ACC  out  4  latched ALU result.
REQ-014 Z  out  1  latched zero flag.
REQ-015 CF  out  1  latched carry flag.
REQ-016 PC  out  4  program counter.
REQ-017 BR_TAKEN  out  1  one-cycle pulse, branch taken.
REQ-018 HALTED  out  1  high while in HALT.

Function
REQ-019 On RES_VALID=1 (RUN or FLUSH), ACC/Z/CF SHALL load RES/Z_IN/CF_IN at the next edge; flags SHALL NOT be recomputed locally.
REQ-020 FSM states SHALL be RUN, FLUSH, HALT.
REQ-021 RUN, PC_EN=1, no taken branch: PC SHALL increment by 1, wrapping 15->0.
REQ-022 BR_COND: 000 always, 001 Z=1, 010 Z=0, 011 CF=1, 100 CF=0, 101/110 never, 111 halt.
REQ-023 Conditions SHALL use the registered Z/CF; a same-cycle RES_VALID update SHALL NOT affect the decision.
REQ-024 Taken branch in RUN: PC<=BR_TARGET, BR_TAKEN=1 for exactly the following cycle, state->FLUSH.
REQ-025 FLUSH SHALL last one cycle: PC held, BR_VALID ignored, then ->RUN.
REQ-026 Not-taken branch SHALL behave as a normal increment with BR_TAKEN=0.
REQ-027 BR_VALID with 111 in RUN and PC_EN=1 SHALL enter HALT next cycle; PC holds.
REQ-028 In HALT all registers SHALL freeze, RES_VALID and BR_VALID ignored; exit only via RST.
REQ-029 BR_TARGET equal to current PC SHALL still be taken, pulse BR_TAKEN and enter FLUSH.

Reset
REQ-030 RST=1 at a rising edge SHALL set ACC=0, Z=0, CF=0, PC=0, BR_TAKEN=0, HALTED=0, state=RUN, overriding all other inputs.
REQ-031 RST mid-FLUSH or in HALT SHALL produce the same reset state, with no residual BR_TAKEN pulse.

Structure
REQ-032 FSM state encodings and BR_COND codes SHALL live in shared package flag_branch_pkg.
REQ-033 Condition decode SHALL be one combinational sub-module, cond_eval (inputs Z, CF, BR_COND; output take, halt).

Verification
REQ-034 Reset, PC_EN=1 for 17 cycles -> PC 0..15, then 0, 1; BR_TAKEN stays 0.
REQ-035 RES_VALID, RES=0, Z_IN=1, CF_IN=0; next cycle BR_VALID, COND=001, TARGET=9 -> PC=9, BR_TAKEN one cycle, PC holds one FLUSH cycle, then 10.
REQ-036 Z registered 0; same cycle RES_VALID Z_IN=1 and BR_VALID COND=001 -> not taken, PC increments, Z=1 afterwards.
REQ-037 BR_VALID COND=111 at PC=5 -> HALTED=1, PC stays 5 for 10 cycles despite RES_VALID/BR_VALID; RST -> all outputs 0.
REQ-038 Taken branch, then RST during FLUSH -> PC=0, BR_TAKEN=0, state RUN, PC=1 next cycle.
